// File: rtl/multiexp_pkg.sv
// Shared types and constants for the multiexp point/scalar stream blocks.
//   FP_TYPE / FE_TYPE : affine point and scalar field element.
//   MODE_*            : feeder run modes (also carried on ctl bit CTL_MODE_BIT).
//   feed_state_e      : feeder FSM states.
//   feed_side_t       : per-beat sideband that travels with the RAM data.
package multiexp_pkg;

    typedef logic [511:0] FP_TYPE;
    typedef logic [255:0] FE_TYPE;

    localparam int FEED_DAT_BITS = $bits(FP_TYPE) + $bits(FE_TYPE);

    localparam logic MODE_NORMAL   = 1'b0;
    localparam logic MODE_COLLAPSE = 1'b1;

    localparam int CTL_MODE_BIT = 0;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_STREAM,
        FEED_DRAIN
    } feed_state_e;

    typedef struct packed {
        logic mode;
        logic sop;
        logic eop;
    } feed_side_t;

endpackage

// File: rtl/multiexp_feed_fifo.sv
// Small synchronous first-word-fall-through FIFO.
//   i_push/i_dat : write side (push while full is dropped unless popping too).
//   i_pop        : consume head (ignored when empty).
//   o_dat        : head entry, straight from the storage registers.
//   o_cnt        : occupancy, used by the feeder's read-credit check.
//   o_empty      : no entries.
module multiexp_feed_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_dat,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dat,
    output logic [$clog2(DEPTH+1)-1:0]   o_cnt,
    output logic                         o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic                        pop_ok, push_ok;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (o_cnt == '0);
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && ((o_cnt != CW'(DEPTH)) || pop_ok);
    assign o_dat   = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_cnt  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= i_dat;
                wr_ptr      <= ptr_nxt(wr_ptr);
            end
            if (pop_ok)
                rd_ptr <= ptr_nxt(rd_ptr);
            o_cnt <= o_cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/multiexp_pnt_scl_feeder.sv
// Point/scalar stream transmitter for the multiexp core.
// Pairs are loaded into an on-chip RAM through the write port while idle;
// a start replays pairs 0..num_in-1 KEY_BITS times (normal) or once (collapse)
// as a valid/ready stream with sop/eop on the first/last index of each pass.
//   i_wr_val/i_wr_addr/i_wr_dat, o_wr_rdy : RAM load port (accepted when idle).
//   i_start/i_mode/i_num_in               : run request.
//   o_busy, o_done, o_err                 : run status pulses/levels.
//   o_pnt_scl_*/i_pnt_scl_rdy             : output stream.
module multiexp_pnt_scl_feeder
    import multiexp_pkg::*;
#(
    parameter int DAT_BITS   = FEED_DAT_BITS,
    parameter int CTL_BITS   = 8,
    parameter int KEY_BITS   = 256,
    parameter int MAX_IN     = 1024,
    parameter int RAM_RD_LAT = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_val,
    input  logic [$clog2(MAX_IN)-1:0]   i_wr_addr,
    input  logic [DAT_BITS-1:0]         i_wr_dat,
    output logic                        o_wr_rdy,
    input  logic                        i_start,
    input  logic                        i_mode,
    input  logic [$clog2(MAX_IN):0]     i_num_in,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output logic                        o_pnt_scl_val,
    input  logic                        i_pnt_scl_rdy,
    output logic [DAT_BITS-1:0]         o_pnt_scl_dat,
    output logic [CTL_BITS-1:0]         o_pnt_scl_ctl,
    output logic                        o_pnt_scl_sop,
    output logic                        o_pnt_scl_eop
);

    localparam int AW    = $clog2(MAX_IN);
    localparam int NW    = AW + 1;
    localparam int PCW   = $clog2(KEY_BITS+1);
    localparam int FDEP  = RAM_RD_LAT + 1;
    localparam int FCW   = $clog2(FDEP+1);
    localparam int FW    = DAT_BITS + $bits(feed_side_t);
    localparam int CRW   = 4;

    logic [DAT_BITS-1:0] mem [MAX_IN];

    feed_state_e   state;
    logic [NW-1:0] num_in;
    logic          mode;
    logic [AW-1:0] rd_idx;
    logic [PCW-1:0] pass_cnt;

    logic          issue, pop, sop_i, eop_i, last_pass;
    logic [CRW-1:0] in_flight;

    logic [RAM_RD_LAT:1]                vld_pipe;
    logic [RAM_RD_LAT:1][DAT_BITS-1:0]  dat_pipe;
    feed_side_t [RAM_RD_LAT:1]          side_pipe;

    logic [FCW-1:0] fifo_cnt;
    logic           fifo_empty;
    logic [FW-1:0]  fifo_q;
    feed_side_t     head_side;

    always_comb begin
        in_flight = '0;
        for (int k = 1; k <= RAM_RD_LAT; k++)
            in_flight = in_flight + CRW'(vld_pipe[k]);
    end

    assign pop       = !fifo_empty && i_pnt_scl_rdy;
    // Credit check: everything already issued plus what sits in the FIFO
    // (net of this cycle's pop) must fit in the FIFO if ready drops for good.
    assign issue     = (state == FEED_STREAM) &&
                       ((in_flight + CRW'(fifo_cnt)) < (CRW'(FDEP) + CRW'(pop)));
    assign sop_i     = (rd_idx == '0);
    assign eop_i     = (NW'(rd_idx) == (num_in - 1'b1));
    assign last_pass = (mode == MODE_COLLAPSE) || (pass_cnt == PCW'(KEY_BITS-1));

    // Load port: only open while idle, so it never races a replay read.
    always_ff @(posedge i_clk) begin
        if (i_wr_val && o_wr_rdy)
            mem[i_wr_addr] <= i_wr_dat;
    end

    // RAM read pipeline; sideband rides alongside the data.
    always_ff @(posedge i_clk) begin
        dat_pipe[1]  <= mem[rd_idx];
        side_pipe[1] <= '{mode: mode, sop: sop_i, eop: eop_i};
        for (int k = 2; k <= RAM_RD_LAT; k++) begin
            dat_pipe[k]  <= dat_pipe[k-1];
            side_pipe[k] <= side_pipe[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue;
            for (int k = 2; k <= RAM_RD_LAT; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    multiexp_feed_fifo #(
        .WIDTH (FW),
        .DEPTH (FDEP)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (vld_pipe[RAM_RD_LAT]),
        .i_dat   ({side_pipe[RAM_RD_LAT], dat_pipe[RAM_RD_LAT]}),
        .i_pop   (pop),
        .o_dat   (fifo_q),
        .o_cnt   (fifo_cnt),
        .o_empty (fifo_empty)
    );

    assign head_side     = feed_side_t'(fifo_q[FW-1:DAT_BITS]);
    assign o_pnt_scl_val = !fifo_empty;
    assign o_pnt_scl_dat = fifo_q[DAT_BITS-1:0];
    assign o_pnt_scl_sop = head_side.sop;
    assign o_pnt_scl_eop = head_side.eop;

    always_comb begin
        o_pnt_scl_ctl               = '0;
        o_pnt_scl_ctl[CTL_MODE_BIT] = head_side.mode;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= FEED_IDLE;
            o_wr_rdy <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            num_in   <= '0;
            mode     <= MODE_NORMAL;
            rd_idx   <= '0;
            pass_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                FEED_IDLE: begin
                    if (i_start) begin
                        if ((i_num_in != '0) && (i_num_in <= NW'(MAX_IN))) begin
                            num_in   <= i_num_in;
                            mode     <= i_mode;
                            rd_idx   <= '0;
                            pass_cnt <= '0;
                            state    <= FEED_STREAM;
                            o_busy   <= 1'b1;
                            o_wr_rdy <= 1'b0;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                FEED_STREAM: begin
                    if (issue) begin
                        if (eop_i) begin
                            rd_idx <= '0;
                            if (last_pass)
                                state <= FEED_DRAIN;
                            else
                                pass_cnt <= pass_cnt + 1'b1;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                FEED_DRAIN: begin
                    // Finish on the handshake of the final beat.
                    if ((in_flight == '0) && (fifo_cnt == FCW'(1)) && pop) begin
                        state    <= FEED_IDLE;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        o_wr_rdy <= 1'b1;
                    end
                end
                default: state <= FEED_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
module tb_multiexp_pnt_scl_feeder;

    localparam int DW  = 768;
    localparam int KB  = 4;
    localparam int MI  = 8;
    localparam int LAT = 2;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [7:0]    ctl;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct {
        logic [3:0] num_in;
        logic       mode;
        logic       rnd;
        logic       exp_err;
        string      nm;
    } vec_t;

    logic          i_clk, i_rst;
    logic          i_wr_val;
    logic [2:0]    i_wr_addr;
    logic [DW-1:0] i_wr_dat;
    logic          o_wr_rdy;
    logic          i_start, i_mode;
    logic [3:0]    i_num_in;
    logic          o_busy, o_done, o_err;
    logic          o_pnt_scl_val, i_pnt_scl_rdy;
    logic [DW-1:0] o_pnt_scl_dat;
    logic [7:0]    o_pnt_scl_ctl;
    logic          o_pnt_scl_sop, o_pnt_scl_eop;

    multiexp_pnt_scl_feeder #(
        .DAT_BITS(DW), .CTL_BITS(8), .KEY_BITS(KB), .MAX_IN(MI), .RAM_RD_LAT(LAT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wr_val(i_wr_val), .i_wr_addr(i_wr_addr), .i_wr_dat(i_wr_dat), .o_wr_rdy(o_wr_rdy),
        .i_start(i_start), .i_mode(i_mode), .i_num_in(i_num_in),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_pnt_scl_val(o_pnt_scl_val), .i_pnt_scl_rdy(i_pnt_scl_rdy),
        .o_pnt_scl_dat(o_pnt_scl_dat), .o_pnt_scl_ctl(o_pnt_scl_ctl),
        .o_pnt_scl_sop(o_pnt_scl_sop), .o_pnt_scl_eop(o_pnt_scl_eop)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] model_ram [MI];

    beat_t cap[$];
    int    cap_cyc[$];
    int    done_cnt, done_cyc, first_val_cyc, stab_bad;
    logic  rnd_rdy = 1'b0;
    logic  stall_prev = 1'b0;
    beat_t prev_beat;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        i_pnt_scl_rdy = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            i_pnt_scl_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Observer: captures every handshake (it completes at the next rising edge).
    always @(negedge i_clk) begin
        beat_t b;
        b = '{dat: o_pnt_scl_dat, ctl: o_pnt_scl_ctl, sop: o_pnt_scl_sop, eop: o_pnt_scl_eop};
        if (i_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (o_pnt_scl_val && stall_prev && (b !== prev_beat))
                stab_bad++;
            stall_prev = o_pnt_scl_val && !i_pnt_scl_rdy;
            prev_beat  = b;
            if (o_pnt_scl_val && first_val_cyc < 0)
                first_val_cyc = cyc;
            if (o_pnt_scl_val && i_pnt_scl_rdy) begin
                cap.push_back(b);
                cap_cyc.push_back(cyc);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input logic [799:0] got, input logic [799:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] d);
        i_wr_val  = 1'b1;
        i_wr_addr = 3'(addr);
        i_wr_dat  = d;
        @(negedge i_clk);
        i_wr_val  = 1'b0;
        model_ram[addr] = d;
    endtask

    task automatic do_run(input logic [3:0] n, input logic md, input logic rnd,
                          input logic mid_wr, input logic exp_err, input string nm);
        beat_t exp_q[$];
        int    c0, k, passes;
        logic  noisy;
        rnd_rdy = rnd;
        cap.delete();
        cap_cyc.delete();
        done_cnt = 0;
        first_val_cyc = -1;
        stab_bad = 0;
        i_start  = 1'b1;
        i_mode   = md;
        i_num_in = n;
        c0 = cyc;
        @(negedge i_clk);
        i_start = 1'b0;
        chk({nm, ":err"},  o_err,  exp_err);
        chk({nm, ":busy"}, o_busy, !exp_err);
        if (exp_err) begin
            noisy = 1'b0;
            repeat (4) begin
                @(negedge i_clk);
                if (o_pnt_scl_val || o_busy || o_err) noisy = 1'b1;
            end
            chk({nm, ":quiet"}, noisy, 1'b0);
            rnd_rdy = 1'b0;
            return;
        end
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(negedge i_clk);
            k++;
            if (mid_wr && k == 2) begin
                chk({nm, ":wr_rdy_busy"}, o_wr_rdy, 1'b0);
                i_wr_val  = 1'b1;
                i_wr_addr = 3'd1;
                i_wr_dat  = DW'('hF);
            end else if (mid_wr && k == 3) begin
                i_wr_val = 1'b0;
            end
        end
        rnd_rdy = 1'b0;
        repeat (2) @(negedge i_clk);
        chk({nm, ":timeout"}, k < 3000, 1'b1);
        // Reference: every pass walks indices 0..n-1 of the RAM image.
        passes = md ? 1 : KB;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < int'(n); i++)
                exp_q.push_back('{dat: model_ram[i], ctl: {7'd0, md},
                                  sop: (i == 0), eop: (i == int'(n) - 1)});
        chk({nm, ":beats"}, cap.size(), exp_q.size());
        for (int b = 0; b < exp_q.size() && b < cap.size(); b++)
            chk($sformatf("%s:beat%0d", nm, b), cap[b], exp_q[b]);
        chk({nm, ":done_cnt"}, done_cnt, 1);
        chk({nm, ":done_at"}, done_cyc, (cap.size() > 0) ? cap_cyc[$] + 1 : -1);
        chk({nm, ":busy_end"}, o_busy, 1'b0);
        chk({nm, ":latency"}, first_val_cyc, c0 + LAT + 2);
        chk({nm, ":stable"}, stab_bad, 0);
        if (!rnd && cap.size() > 0)
            chk({nm, ":no_bubble"}, cap_cyc[$] - cap_cyc[0], exp_q.size() - 1);
    endtask

    vec_t tbl[8];

    initial begin
        logic [DW-1:0] d;
        int k;
        tbl[0] = '{4'd0,  1'b0, 1'b0, 1'b1, "n0"};
        tbl[1] = '{4'd9,  1'b0, 1'b0, 1'b1, "n9"};
        tbl[2] = '{4'd15, 1'b1, 1'b0, 1'b1, "n15"};
        tbl[3] = '{4'd1,  1'b0, 1'b0, 1'b0, "n1"};
        tbl[4] = '{4'd8,  1'b0, 1'b1, 1'b0, "n8_rnd"};
        tbl[5] = '{4'd5,  1'b1, 1'b1, 1'b0, "n5_col_rnd"};
        tbl[6] = '{4'd8,  1'b1, 1'b0, 1'b0, "n8_col"};
        tbl[7] = '{4'd3,  1'b0, 1'b1, 1'b0, "n3_rnd"};

        i_rst = 1'b1; i_wr_val = 1'b0; i_wr_addr = '0; i_wr_dat = '0;
        i_start = 1'b0; i_mode = 1'b0; i_num_in = '0;
        repeat (3) @(negedge i_clk);
        chk("rst:val",    o_pnt_scl_val, 1'b0);
        chk("rst:busy",   o_busy, 1'b0);
        chk("rst:done",   o_done, 1'b0);
        chk("rst:err",    o_err, 1'b0);
        chk("rst:wr_rdy", o_wr_rdy, 1'b1);
        chk("rst:out",    {o_pnt_scl_dat, o_pnt_scl_ctl, o_pnt_scl_sop, o_pnt_scl_eop}, '0);
        i_rst = 1'b0;
        @(negedge i_clk);

        wr(0, DW'('hA)); wr(1, DW'('hB)); wr(2, DW'('hC));
        do_run(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, "base");
        do_run(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, "stall");

        wr(0, DW'('h5)); wr(1, DW'('h6));
        do_run(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, "collapse");

        for (int a = 0; a < MI; a++) begin
            for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
            wr(a, d);
        end
        for (int t = 0; t < 8; t++)
            do_run(tbl[t].num_in, tbl[t].mode, tbl[t].rnd, 1'b0, tbl[t].exp_err, tbl[t].nm);

        // Reset in the middle of a run, then replay from the retained RAM.
        wr(0, DW'('hA)); wr(1, DW'('hB)); wr(2, DW'('hC));
        cap.delete();
        i_start = 1'b1; i_mode = 1'b0; i_num_in = 4'd3;
        @(negedge i_clk);
        i_start = 1'b0;
        k = 0;
        while (cap.size() < 5 && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        chk("midrst:reach5", cap.size() >= 5, 1'b1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst:val",  o_pnt_scl_val, 1'b0);
        chk("midrst:busy", o_busy, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        do_run(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, "restart");

        // Write while busy is dropped; the same write once idle lands.
        do_run(4'd3, 1'b0, 1'b0, 1'b1, 1'b0, "wr_busy");
        chk("wr_idle:rdy", o_wr_rdy, 1'b1);
        wr(1, DW'('hF));
        do_run(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, "wr_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiexp_pnt_scl_feeder.md
Name: multiexp_pnt_scl_feeder

Overview:
- Transmitter for the multiexp core's point/scalar stream.
- Holds up to MAX_IN {point, scalar} pairs in on-chip RAM, loaded via a simple write port.
- On start, replays pairs 0..num_in-1 once per key bit (KEY_BITS passes) in normal mode, or a single pass with ctl[0]=1 in collapse mode.
- Full valid/ready backpressure; sustains one beat per cycle.

Parameters:
- DAT_BITS, 768: width of one {FP_TYPE, FE_TYPE} pair, point in upper bits, scalar in lower.
- CTL_BITS, 8: stream ctl width.
- KEY_BITS, 256: scalar bits, equal to passes per normal-mode run.
- MAX_IN, 1024: RAM depth (pairs).
- RAM_RD_LAT, 2: RAM read latency in cycles (1..4).

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset.
- i_wr_val, in, 1: RAM write strobe.
- i_wr_addr, in, $clog2(MAX_IN): write index.
- i_wr_dat, in, DAT_BITS: pair to store.
- o_wr_rdy, out, 1: write accepted when high (IDLE only).
- i_start, in, 1: start pulse.
- i_mode, in, 1: 0 normal, 1 collapse.
- i_num_in, in, $clog2(MAX_IN)+1: pairs per pass.
- o_busy, out, 1: run in progress.
- o_done, out, 1: 1-cycle pulse after the last beat handshake.
- o_err, out, 1: 1-cycle pulse on an illegal start.
- o_pnt_scl_val, out, 1: stream valid.
- i_pnt_scl_rdy, in, 1: stream ready.
- o_pnt_scl_dat, out, DAT_BITS: pair.
- o_pnt_scl_ctl, out, CTL_BITS: bit 0 = mode; other bits 0.
- o_pnt_scl_sop, out, 1: high on index 0 of each pass.
- o_pnt_scl_eop, out, 1: high on index num_in-1 of each pass.

Behaviour:
- Reset and clock: i_rst is synchronous, active-high; clock is i_clk. Reset values:
  - o_pnt_scl_val, o_busy, o_done, o_err = 0; o_wr_rdy = 1.
  - Counters and FIFO cleared; dat/ctl/sop/eop = 0.
  - RAM contents are not cleared.
- FSM states:
  - IDLE: o_wr_rdy=1; writes land the same cycle.
    - i_start with 1<=i_num_in<=MAX_IN: latch num_in and mode, pass_cnt=0, rd_idx=0, go to STREAM, o_busy=1.
    - i_start with an illegal i_num_in: o_err pulse next cycle, stay IDLE.
  - STREAM: issue one RAM read per cycle while in_flight+fifo_cnt < RAM_RD_LAT+1 (credit scheme, so the FIFO never overflows).
    - rd_idx wraps num_in-1 -> 0 and increments pass_cnt.
    - After issuing index num_in-1 of the final pass (KEY_BITS-1 normal, 0 collapse), go to DRAIN.
  - DRAIN: no reads; wait for the FIFO to empty and in-flight reads to complete, then IDLE.
    - o_done pulses the cycle after the last handshake; o_busy drops the same cycle.
- Read sideband: sop/eop flags are computed at read issue and carried through the RAM pipeline and FIFO alongside the data.
- Output FIFO:
  - Depth RAM_RD_LAT+1.
  - Output is registered first-word-fall-through: dat/ctl/sop/eop come from the FIFO head.
  - o_pnt_scl_val = FIFO not empty.
- Latency: i_start sampled at cycle 0 -> first read at cycle 1 -> o_pnt_scl_val high at cycle RAM_RD_LAT+2 (4 with defaults).
- Throughput: with rdy held high, 1 beat/cycle with no bubbles, including across pass boundaries.
- Beat counts: normal run emits num_in*KEY_BITS beats; collapse run emits num_in beats.
- Handshake: while val && !rdy, dat/ctl/sop/eop stay stable. A beat is consumed only on val&&rdy.
- Simultaneous write and start in IDLE: the write commits; the read of that address on cycle 1 sees the new data.
- Ignored inputs:
  - i_start while busy.
  - i_wr_val while o_wr_rdy=0 (data discarded).
- num_in=1: every beat has sop=eop=1.
- Reset mid-run: next cycle val=0, busy=0, FIFO flushed, in-flight reads dropped; RAM retains data.
- Counter widths: pass_cnt is $clog2(KEY_BITS+1) bits; no wrap hazard at KEY_BITS-1.

Decomposition:
- Shared package (multiexp_pkg):
  - FP_TYPE/FE_TYPE typedefs (DAT_BITS = $bits(FP_TYPE)+$bits(FE_TYPE)).
  - MODE_NORMAL=0, MODE_COLLAPSE=1.
  - CTL bit index constants.
- Sub-module multiexp_feed_fifo: small synchronous FWFT FIFO, parameterised width/depth, with count output for the credit check.
- RAM inferred inline with a RAM_RD_LAT pipeline.

Test Plan:
- KEY_BITS=4, num_in=3, RAM[0..2]=0xA,0xB,0xC, rdy=1 -> 12 beats A,B,C x4.
  - sop on A, eop on C, ctl=0.
  - val at cycle 4; o_done once, one cycle after beat 12.
- Same run with rdy random 50% -> identical 12-beat sequence, no drop/dup, dat stable while stalled, no FIFO overflow.
- i_mode=1, num_in=2, RAM=0x5,0x6 -> exactly 2 beats with ctl[0]=1, sop on 0x5, eop on 0x6, then done.
- i_num_in=0 and i_num_in=MAX_IN+1 -> o_err pulse each, no val, o_busy stays 0.
- Reset asserted after beat 5 of a normal run -> val=0, busy=0 next cycle.
  - Restart emits the full sequence from index 0 with the original RAM data.
- Write to addr 1 with 0xF during a run -> o_wr_rdy=0, all passes still show 0xB.
  - After done, write accepted; next run shows 0xF.
